// File: rtl/sdram_init_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_checker_if
// Description : SDRAM command bus bundle (cmd, bank address, address) as
//               seen between a controller and the device.
//               master : the side driving the bus (controller / stimulus)
//               slave  : the side observing the bus (device / monitor)
//   sdram_cmd  [3:0]  {cs_n, ras_n, cas_n, we_n}
//   sdram_ba   [1:0]  bank address
//   sdram_addr [12:0] address bus
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_init_checker_if;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  modport master (output sdram_cmd, output sdram_ba, output sdram_addr);
  modport slave  (input  sdram_cmd, input  sdram_ba, input  sdram_addr);
endinterface
`default_nettype wire

// File: rtl/sdram_init_checker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_checker
// Description : Passive monitor of the SDRAM power-up initialization
//               sequence. Checks command order and NOP spacing, reports the
//               programmed mode register on success, and latches the first
//               violation as a sticky error code. Drives nothing on the bus.
// Ports       :
//   sys_clk     in   system clock, bus sampled on rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   bus         in   sdram_init_checker_if.slave (cmd / ba / addr)
//   init_done   out  sequence completed legally (sticky)
//   init_err    out  violation detected (sticky until reset)
//   err_code    out  0 none, 1 power-up short, 2 order, 3 spacing,
//                    4 too few refreshes, 5 bad mode word
//   aref_count  out  accepted AUTO_REFRESH count, saturates at 15
//   mode_bl/bt/cl/wbm out  latched mode register fields
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_checker #(
  parameter int unsigned T_POWERUP = 20000,
  parameter int unsigned TRP       = 2,
  parameter int unsigned TRFC      = 7,
  parameter int unsigned TMRD      = 3,
  parameter int unsigned AREF_NUM  = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  sdram_init_checker_if.slave    bus,
  output logic                   init_done,
  output logic                   init_err,
  output logic [2:0]             err_code,
  output logic [3:0]             aref_count,
  output logic [2:0]             mode_bl,
  output logic                   mode_bt,
  output logic [2:0]             mode_cl,
  output logic                   mode_wbm
);

  localparam logic [14:0] C_T_POWERUP = 15'(T_POWERUP);
  localparam logic [3:0]  C_TRP       = 4'(TRP);
  localparam logic [3:0]  C_TRFC      = 4'(TRFC);
  localparam logic [3:0]  C_TMRD      = 4'(TMRD);
  localparam logic [3:0]  C_AREF_NUM  = 4'(AREF_NUM);

  localparam logic [3:0]  C_CMD_NOP   = 4'b0111;
  localparam logic [3:0]  C_CMD_PRE   = 4'b0010;
  localparam logic [3:0]  C_CMD_AREF  = 4'b0001;
  localparam logic [3:0]  C_CMD_LMR   = 4'b0000;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_TRP   = 3'd1,
    ST_TRFC  = 3'd2,
    ST_TMRD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]  aref_count_q, aref_count_d;
  logic [2:0]  err_code_q, err_code_d;
  // {wbm, cl[2:0], bt, bl[2:0]}
  logic [7:0]  mode_q, mode_d;

  logic [2:0]  viol_code;
  logic        w_nop, w_pre, w_aref, w_lmr, w_mode_ok;

  // Address bits 8:7 carry no mode information the checker cares about.
  logic        w_unused_addr;
  assign w_unused_addr = &{1'b0, bus.sdram_addr[8:7]};

  // Deselect (cs_n high) is treated exactly like an explicit NOP.
  assign w_nop  = bus.sdram_cmd[3] | (bus.sdram_cmd == C_CMD_NOP);
  assign w_pre  = (bus.sdram_cmd == C_CMD_PRE);
  assign w_aref = (bus.sdram_cmd == C_CMD_AREF);
  assign w_lmr  = (bus.sdram_cmd == C_CMD_LMR);

  // Only all-bank addressing in bank 0 with CAS latency 2 or 3 is accepted.
  assign w_mode_ok = (bus.sdram_ba == 2'b00) &&
                     (bus.sdram_addr[12:10] == 3'b000) &&
                     ((bus.sdram_addr[6:4] == 3'b010) ||
                      (bus.sdram_addr[6:4] == 3'b011));

  always_comb begin
    state_d      = state_q;
    pwr_cnt_d    = pwr_cnt_q;
    aref_count_d = aref_count_q;
    err_code_d   = err_code_q;
    mode_d       = mode_q;
    viol_code    = 3'd0;

    if (!w_nop) begin
      gap_cnt_d = 4'd0;
    end else if (gap_cnt_q != 4'hF) begin
      gap_cnt_d = gap_cnt_q + 4'd1;
    end else begin
      gap_cnt_d = gap_cnt_q;
    end

    // Within each state the checks are ordered so that timing violations
    // win over refresh count, refresh count over mode word, and mode word
    // over command order.
    case (state_q)
      ST_PWRUP: begin
        if (w_nop) begin
          if (pwr_cnt_q != 15'h7FFF) pwr_cnt_d = pwr_cnt_q + 15'd1;
        end else if (pwr_cnt_q < C_T_POWERUP) begin
          viol_code = 3'd1;
        end else if (w_pre && bus.sdram_addr[10]) begin
          state_d = ST_TRP;
        end else begin
          viol_code = 3'd2;
        end
      end
      ST_TRP: begin
        if (!w_nop) begin
          if (gap_cnt_q < C_TRP) begin
            viol_code = 3'd3;
          end else if (w_aref) begin
            aref_count_d = 4'd1;
            state_d      = ST_TRFC;
          end else begin
            viol_code = 3'd2;
          end
        end
      end
      ST_TRFC: begin
        if (!w_nop) begin
          if (gap_cnt_q < C_TRFC) begin
            viol_code = 3'd3;
          end else if (w_aref) begin
            if (aref_count_q != 4'hF) aref_count_d = aref_count_q + 4'd1;
          end else if (w_lmr) begin
            if (aref_count_q < C_AREF_NUM) begin
              viol_code = 3'd4;
            end else if (!w_mode_ok) begin
              viol_code = 3'd5;
            end else begin
              mode_d  = {bus.sdram_addr[9], bus.sdram_addr[6:0]};
              state_d = ST_TMRD;
            end
          end else begin
            viol_code = 3'd2;
          end
        end
      end
      ST_TMRD: begin
        if (!w_nop) begin
          viol_code = 3'd3;
        end else if (gap_cnt_d >= C_TMRD) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      ST_ERR:  ;
      default: state_d = ST_ERR;
    endcase

    if (viol_code != 3'd0) begin
      state_d    = ST_ERR;
      err_code_d = viol_code;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_PWRUP;
      pwr_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      aref_count_q <= '0;
      err_code_q   <= '0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      aref_count_q <= aref_count_d;
      err_code_q   <= err_code_d;
      mode_q       <= mode_d;
    end
  end

  assign init_done  = (state_q == ST_DONE);
  assign init_err   = (state_q == ST_ERR);
  assign err_code   = err_code_q;
  assign aref_count = aref_count_q;
  assign mode_bl    = mode_q[2:0];
  assign mode_bt    = mode_q[3];
  assign mode_cl    = mode_q[6:4];
  assign mode_wbm   = mode_q[7];

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_init_checker
// Description : Self-checking bench for sdram_init_checker. A sequence-level
//               model (rules applied per non-NOP command by its position in
//               the init sequence) is compared against the DUT every cycle,
//               and literal checkpoints pin the expected results of each
//               directed scenario. The power-up wait is shortened so that
//               every scenario can start from a legal power-up.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_init_checker;

  localparam int C_TPU      = 256;
  localparam int C_TRP      = 2;
  localparam int C_TRFC     = 7;
  localparam int C_TMRD     = 3;
  localparam int C_AREF_NUM = 8;

  localparam logic [3:0] K_NOP  = 4'b0111;
  localparam logic [3:0] K_PRE  = 4'b0010;
  localparam logic [3:0] K_AREF = 4'b0001;
  localparam logic [3:0] K_LM   = 4'b0000;
  localparam logic [3:0] K_ACT  = 4'b0011;
  localparam logic [3:0] K_READ = 4'b0101;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       init_done, init_err, mode_bt, mode_wbm;
  logic [2:0] err_code, mode_bl, mode_cl;
  logic [3:0] aref_count;

  sdram_init_checker_if bus_if ();

  sdram_init_checker #(
    .T_POWERUP (C_TPU),
    .TRP       (C_TRP),
    .TRFC      (C_TRFC),
    .TMRD      (C_TMRD),
    .AREF_NUM  (C_AREF_NUM)
  ) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bus        (bus_if.slave),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_code   (err_code),
    .aref_count (aref_count),
    .mode_bl    (mode_bl),
    .mode_bt    (mode_bt),
    .mode_cl    (mode_cl),
    .mode_wbm   (mode_wbm)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- sequence-level model ----------------
  int         m_nops, m_nev, m_aref;
  bit         m_lm, m_done, m_err;
  logic [2:0] m_code;
  logic [7:0] m_mode;   // {wbm, cl, bt, bl}
  int         m_rule;

  function automatic bit is_nop(input logic [3:0] c);
    return c[3] || (c == K_NOP);
  endfunction

  // Violation code for a non-NOP command, given how many NOPs preceded it,
  // its position among non-NOP commands, and the progress made so far.
  function automatic int rule_code(input logic [3:0] c, input logic [1:0] ba,
                                   input logic [12:0] a, input int gap,
                                   input int nev, input bit lm, input int nref);
    if (nev == 0) begin
      if (gap < C_TPU) return 1;
      if (!(c == K_PRE && a[10])) return 2;
      return 0;
    end
    if (nev == 1) begin
      if (gap < C_TRP) return 3;
      return (c == K_AREF) ? 0 : 2;
    end
    if (lm) return 3;
    if (gap < C_TRFC) return 3;
    if (c == K_AREF) return 0;
    if (c != K_LM) return 2;
    if (nref < C_AREF_NUM) return 4;
    if (ba != 2'b00 || a[12:10] != 3'b000 || (a[6:4] != 3'b010 && a[6:4] != 3'b011)) return 5;
    return 0;
  endfunction

  always_comb m_rule = rule_code(bus_if.sdram_cmd, bus_if.sdram_ba, bus_if.sdram_addr,
                                 m_nops, m_nev, m_lm, m_aref);

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_nops <= 0; m_nev <= 0; m_aref <= 0;
      m_lm <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_code <= 3'd0; m_mode <= 8'd0;
    end else if (!m_done && !m_err) begin
      if (is_nop(bus_if.sdram_cmd)) begin
        m_nops <= m_nops + 1;
        if (m_lm && (m_nops + 1 >= C_TMRD)) m_done <= 1'b1;
      end else begin
        m_nops <= 0;
        m_nev  <= m_nev + 1;
        if (m_rule != 0) begin
          m_err  <= 1'b1;
          m_code <= 3'(m_rule);
        end else if (m_nev == 1) begin
          m_aref <= 1;
        end else if (bus_if.sdram_cmd == K_AREF) begin
          m_aref <= (m_aref < 15) ? m_aref + 1 : 15;
        end else if (bus_if.sdram_cmd == K_LM) begin
          m_lm   <= 1'b1;
          m_mode <= {bus_if.sdram_addr[9], bus_if.sdram_addr[6:0]};
        end
      end
    end
  end

  // Every-cycle comparison, away from the sampling edge.
  always @(negedge sys_clk) begin
    chk("cmp_done", 16'(init_done), 16'(m_done));
    chk("cmp_err",  16'(init_err),  16'(m_err));
    chk("cmp_code", 16'(err_code),  16'(m_code));
    chk("cmp_aref", 16'(aref_count), 16'(m_aref));
    chk("cmp_mode", 16'({mode_wbm, mode_cl, mode_bt, mode_bl}), 16'(m_mode));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
    @(negedge sys_clk);
    bus_if.sdram_cmd  = c;
    bus_if.sdram_ba   = ba;
    bus_if.sdram_addr = a;
  endtask

  // Alternates explicit NOP with deselect carrying random junk.
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) drive(K_NOP, 2'($urandom), 13'($urandom));
      else            drive({1'b1, 3'($urandom)}, 2'($urandom), 13'($urandom));
    end
  endtask

  task automatic refresh(input int k, input int gap);
    for (int i = 0; i < k; i++) begin
      drive(K_AREF, 2'b00, 13'h0000);
      nops(gap);
    end
  endtask

  // Drives one NOP; outputs then reflect the previously driven command.
  task automatic cp();
    drive(K_NOP, 2'b00, 13'h0000);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    bus_if.sdram_cmd = K_NOP; bus_if.sdram_ba = 2'b00; bus_if.sdram_addr = 13'h0;
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic run_nominal();
    nops(C_TPU + 1);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(3);
    refresh(8, 8);
    drive(K_LM, 2'b00, 13'h037);
    nops(2);
    cp();
    chk("nom_done_early", 16'(init_done), 16'd0);
    cp();
    chk("nom_done", 16'(init_done), 16'd1);
    chk("nom_err",  16'(init_err),  16'd0);
    chk("nom_aref", 16'(aref_count), 16'd8);
    chk("nom_bl",   16'(mode_bl),   16'd7);
    chk("nom_bt",   16'(mode_bt),   16'd0);
    chk("nom_cl",   16'(mode_cl),   16'd3);
    chk("nom_wbm",  16'(mode_wbm),  16'd0);
  endtask

  initial begin
    bus_if.sdram_cmd = K_NOP; bus_if.sdram_ba = 2'b00; bus_if.sdram_addr = 13'h0;
    #1;
    chk("rst_done", 16'(init_done), 16'd0);
    chk("rst_err",  16'(init_err),  16'd0);
    chk("rst_aref", 16'(aref_count), 16'd0);

    // Nominal, then normal traffic after DONE must be ignored
    do_reset();
    run_nominal();
    drive(K_ACT, 2'b01, 13'h0123);
    drive(K_READ, 2'b01, 13'h0400);
    drive(K_PRE, 2'b00, 13'h0000);
    cp();
    chk("traffic_err",  16'(init_err),  16'd0);
    chk("traffic_done", 16'(init_done), 16'd1);

    // Early command
    do_reset();
    nops(100);
    drive(K_PRE, 2'b00, 13'h1FFF);
    cp();
    chk("early_err",  16'(init_err),  16'd1);
    chk("early_code", 16'(err_code),  16'd1);
    chk("early_done", 16'(init_done), 16'd0);

    // Power-up boundary: one NOP short
    do_reset();
    nops(C_TPU - 1);
    drive(K_PRE, 2'b00, 13'h1FFF);
    cp();
    chk("pwr_short_code", 16'(err_code), 16'd1);

    // Exactly T_POWERUP NOPs accepted, then PRECHARGE-to-refresh too close
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h0400);
    cp();
    chk("pwr_exact_err", 16'(init_err), 16'd0);
    drive(K_AREF, 2'b00, 13'h0);
    cp();
    chk("trp_viol_code", 16'(err_code), 16'd3);

    // 7 NOPs after PRECHARGE accepted; only 7 refreshes with bad mode word
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(7);
    drive(K_AREF, 2'b00, 13'h0);
    cp();
    chk("trp_ok_err",  16'(init_err),  16'd0);
    chk("trp_ok_aref", 16'(aref_count), 16'd1);
    nops(6);
    refresh(6, 7);
    drive(K_LM, 2'b00, 13'h017);
    cp();
    chk("few_aref_code", 16'(err_code),  16'd4);
    chk("few_aref_cnt",  16'(aref_count), 16'd7);

    // 8 refreshes (tRP and tRFC at their exact minimum), CL=1 mode word
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    refresh(8, 7);
    drive(K_LM, 2'b00, 13'h017);
    cp();
    chk("bad_mode_code", 16'(err_code), 16'd5);
    chk("bad_mode_aref", 16'(aref_count), 16'd8);
    chk("bad_mode_cl",   16'(mode_cl),  16'd0);

    // Mode word with nonzero bank address
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    refresh(8, 7);
    drive(K_LM, 2'b01, 13'h037);
    cp();
    chk("bad_ba_code", 16'(err_code), 16'd5);

    // ACTIVE instead of PRECHARGE
    do_reset();
    nops(C_TPU);
    drive(K_ACT, 2'b00, 13'h1FFF);
    cp();
    chk("order_code", 16'(err_code), 16'd2);

    // Refresh-to-refresh one NOP short
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    drive(K_AREF, 2'b00, 13'h0);
    nops(6);
    drive(K_AREF, 2'b00, 13'h0);
    cp();
    chk("trfc_code", 16'(err_code),  16'd3);
    chk("trfc_aref", 16'(aref_count), 16'd1);

    // Refresh count saturation, then an alternate legal mode word
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    refresh(16, 7);
    cp();
    chk("sat_aref", 16'(aref_count), 16'd15);
    drive(K_LM, 2'b00, 13'h22B);
    nops(2);
    cp();
    cp();
    chk("alt_done", 16'(init_done), 16'd1);
    chk("alt_bl",   16'(mode_bl),   16'd3);
    chk("alt_bt",   16'(mode_bt),   16'd1);
    chk("alt_cl",   16'(mode_cl),   16'd2);
    chk("alt_wbm",  16'(mode_wbm),  16'd1);

    // Command during tMRD
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    refresh(8, 7);
    drive(K_LM, 2'b00, 13'h037);
    nops(1);
    drive(K_AREF, 2'b00, 13'h0);
    cp();
    chk("tmrd_code", 16'(err_code),  16'd3);
    chk("tmrd_done", 16'(init_done), 16'd0);

    // Asynchronous reset after the 4th refresh, then a full re-run
    do_reset();
    nops(C_TPU);
    drive(K_PRE, 2'b00, 13'h1FFF);
    nops(2);
    refresh(3, 7);
    drive(K_AREF, 2'b00, 13'h0);
    cp();
    chk("mid_aref", 16'(aref_count), 16'd4);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_aref", 16'(aref_count), 16'd0);
    chk("async_err",  16'(init_err),   16'd0);
    chk("async_done", 16'(init_done),  16'd0);
    chk("async_code", 16'(err_code),   16'd0);
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    run_nominal();

    repeat (2) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
